// File: rtl/pc_gen_pkg.sv
// Shared fetch-PC definitions: next-PC select encodings and default vectors.
// Also used by the controller when driving npc_sel.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'b00,
        NPC_B   = 2'b01,
        NPC_J   = 2'b10,
        NPC_JR  = 2'b11
    } npc_sel_e;

    typedef enum logic [2:0] {
        SRC_EXC,
        SRC_ERET,
        SRC_HOLD,
        SRC_PEND,
        SRC_LIVE,
        SRC_SEQ
    } pc_src_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] EXC_PC_DEF   = 32'h0000_4180;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational control-transfer targets and link address for the ID-stage
// instruction.
module pc_target_calc
    import pc_gen_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] pc_id,
    input  logic [15:0]      imm16,
    input  logic [25:0]      imm26,
    input  logic [WIDTH-1:0] rs_val,
    output logic [WIDTH-1:0] b_tgt,
    output logic [WIDTH-1:0] j_tgt,
    output logic [WIDTH-1:0] jr_tgt,
    output logic [WIDTH-1:0] link_addr
);

    logic [WIDTH-1:0] seq_id;
    logic [WIDTH-1:0] b_off;

    assign seq_id    = pc_id + WIDTH'(4);
    assign b_off     = {{(WIDTH-18){imm16[15]}}, imm16, 2'b00};
    assign b_tgt     = seq_id + b_off;
    assign jr_tgt    = rs_val;
    assign link_addr = pc_id + WIDTH'(8);

    // The jump region comes from the delay-slot PC, not the jump itself.
    generate
        if (WIDTH > 28) begin : g_region
            assign j_tgt = {seq_id[WIDTH-1:28], imm26, 2'b00};
        end else begin : g_flat
            assign j_tgt = {imm26, 2'b00};
        end
    endgenerate

endmodule

// File: rtl/pc_gen.sv
// IF-stage PC register with next-PC priority mux, exception/eret override
// and a one-entry buffer for redirects that arrive while fetch is held.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEF),
    parameter logic [WIDTH-1:0] EXC_PC   = WIDTH'(EXC_PC_DEF)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fetch_hold,
    input  logic [1:0]       npc_sel,
    input  logic             judge,
    input  logic [WIDTH-1:0] pc_id,
    input  logic [15:0]      imm16,
    input  logic [25:0]      imm26,
    input  logic [WIDTH-1:0] rs_val,
    input  logic             exc_req,
    input  logic             eret_req,
    input  logic [WIDTH-1:0] epc_in,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_4,
    output logic [WIDTH-1:0] link_addr,
    output logic             if_jump,
    output logic             pend_valid,
    output logic             pc_misalign
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pend_tgt_q;
    logic             pend_valid_q;

    logic [WIDTH-1:0] b_tgt;
    logic [WIDTH-1:0] j_tgt;
    logic [WIDTH-1:0] jr_tgt;

    npc_sel_e         sel;
    logic             live_redir;
    logic [WIDTH-1:0] live_tgt;

    pc_src_e          src;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pend_tgt_d;
    logic             pend_valid_d;
    logic             jump_c;

    pc_target_calc #(
        .WIDTH(WIDTH)
    ) u_tgt (
        .pc_id    (pc_id),
        .imm16    (imm16),
        .imm26    (imm26),
        .rs_val   (rs_val),
        .b_tgt    (b_tgt),
        .j_tgt    (j_tgt),
        .jr_tgt   (jr_tgt),
        .link_addr(link_addr)
    );

    assign sel  = npc_sel_e'(npc_sel);
    assign pc_4 = pc_q + WIDTH'(4);

    always_comb begin
        live_redir = 1'b0;
        live_tgt   = pc_4;
        unique case (sel)
            NPC_SEQ: begin
                live_redir = 1'b0;
                live_tgt   = pc_4;
            end
            NPC_B: begin
                live_redir = judge;
                live_tgt   = b_tgt;
            end
            NPC_J: begin
                live_redir = 1'b1;
                live_tgt   = j_tgt;
            end
            NPC_JR: begin
                live_redir = 1'b1;
                live_tgt   = jr_tgt;
            end
        endcase
    end

    always_comb begin
        src = SRC_SEQ;
        if (exc_req) begin
            src = SRC_EXC;
        end else if (eret_req) begin
            src = SRC_ERET;
        end else if (fetch_hold) begin
            src = SRC_HOLD;
        end else if (pend_valid_q) begin
            src = SRC_PEND;
        end else if (live_redir) begin
            src = SRC_LIVE;
        end
    end

    always_comb begin
        pc_d         = pc_q;
        pend_valid_d = pend_valid_q;
        pend_tgt_d   = pend_tgt_q;
        jump_c       = 1'b0;
        unique case (src)
            SRC_EXC: begin
                pc_d         = EXC_PC;
                pend_valid_d = 1'b0;
                jump_c       = 1'b1;
            end
            SRC_ERET: begin
                pc_d         = epc_in;
                pend_valid_d = 1'b0;
                jump_c       = 1'b1;
            end
            SRC_HOLD: begin
                // First redirect seen during a hold wins; later ones drop.
                if (live_redir && !pend_valid_q) begin
                    pend_valid_d = 1'b1;
                    pend_tgt_d   = live_tgt;
                end
            end
            SRC_PEND: begin
                pc_d         = pend_tgt_q;
                pend_valid_d = 1'b0;
                jump_c       = 1'b1;
            end
            SRC_LIVE: begin
                pc_d   = live_tgt;
                jump_c = 1'b1;
            end
            SRC_SEQ: begin
                pc_d = pc_4;
            end
            default: begin
                pc_d = pc_4;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            pend_valid_q <= 1'b0;
            pend_tgt_q   <= '0;
        end else begin
            pc_q         <= pc_d;
            pend_valid_q <= pend_valid_d;
            pend_tgt_q   <= pend_tgt_d;
        end
    end

    assign pc          = pc_q;
    assign pend_valid  = pend_valid_q;
    assign if_jump     = jump_c & ~reset;
    assign pc_misalign = |pc_q[1:0];

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: expected PCs are queued when stimulus is driven
// and popped when the following edge produces the new PC.
module tb_pc_gen;
    import pc_gen_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_hold = 1'b0;
    logic [1:0]  npc_sel = 2'b00;
    logic        judge = 1'b0;
    logic [31:0] pc_id = '0;
    logic [15:0] imm16 = '0;
    logic [25:0] imm26 = '0;
    logic [31:0] rs_val = '0;
    logic        exc_req = 1'b0;
    logic        eret_req = 1'b0;
    logic [31:0] epc_in = '0;

    logic [31:0] pc;
    logic [31:0] pc_4;
    logic [31:0] link_addr;
    logic        if_jump;
    logic        pend_valid;
    logic        pc_misalign;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];

    pc_gen dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_hold (fetch_hold),
        .npc_sel    (npc_sel),
        .judge      (judge),
        .pc_id      (pc_id),
        .imm16      (imm16),
        .imm26      (imm26),
        .rs_val     (rs_val),
        .exc_req    (exc_req),
        .eret_req   (eret_req),
        .epc_in     (epc_in),
        .pc         (pc),
        .pc_4       (pc_4),
        .link_addr  (link_addr),
        .if_jump    (if_jump),
        .pend_valid (pend_valid),
        .pc_misalign(pc_misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [31:0] exp_pc,
                        input logic exp_jump);
        exp_t e;
        #1;
        chk({tag, "_if_jump"}, 32'(if_jump), 32'(exp_jump));
        sb.push_back('{tag, exp_pc});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_underflow"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_pc"}, pc, e.pc);
        end
    endtask

    initial begin
        #12;
        chk("rst_pc", pc, 32'h0000_3000);
        chk("rst_pend", 32'(pend_valid), 32'd0);
        chk("rst_if_jump", 32'(if_jump), 32'd0);
        chk("rst_misalign", 32'(pc_misalign), 32'd0);
        reset = 1'b0;

        step("seq1", 32'h0000_3004, 1'b0);
        step("seq2", 32'h0000_3008, 1'b0);
        step("seq3", 32'h0000_300C, 1'b0);
        chk("pc_4", pc_4, 32'h0000_3010);

        pc_id = 32'h0000_3010; npc_sel = 2'b01; judge = 1'b1;
        imm16 = 16'hFFFC;
        step("br_taken", 32'h0000_3004, 1'b1);
        judge = 1'b0;
        step("br_not_taken", 32'h0000_3008, 1'b0);

        fetch_hold = 1'b1; npc_sel = 2'b10;
        pc_id = 32'h0000_3020; imm26 = 26'h0000C40;
        step("hold_j", 32'h0000_3008, 1'b0);
        chk("hold_pend_set", 32'(pend_valid), 32'd1);
        npc_sel = 2'b11; rs_val = 32'h0000_5000;
        step("hold_second_redir", 32'h0000_3008, 1'b0);
        npc_sel = 2'b00;
        step("hold3", 32'h0000_3008, 1'b0);
        chk("hold_pend_kept", 32'(pend_valid), 32'd1);

        fetch_hold = 1'b0; npc_sel = 2'b11; rs_val = 32'h5555_0000;
        step("pend_apply", 32'h0000_3100, 1'b1);
        chk("pend_clear", 32'(pend_valid), 32'd0);
        npc_sel = 2'b00;
        step("after_pend", 32'h0000_3104, 1'b0);

        fetch_hold = 1'b1; npc_sel = 2'b10;
        step("hold_j2", 32'h0000_3104, 1'b0);
        chk("hold_pend_set2", 32'(pend_valid), 32'd1);
        exc_req = 1'b1; eret_req = 1'b1; epc_in = 32'h0000_3008;
        step("exc_over_hold", 32'h0000_4180, 1'b1);
        chk("exc_pend_clear", 32'(pend_valid), 32'd0);
        exc_req = 1'b0;
        step("eret", 32'h0000_3008, 1'b1);
        eret_req = 1'b0; fetch_hold = 1'b0;

        npc_sel = 2'b11; rs_val = 32'h0000_3002; pc_id = 32'h0000_3040;
        #1;
        chk("link_addr", link_addr, 32'h0000_3048);
        step("jr_unaligned", 32'h0000_3002, 1'b1);
        chk("misalign", 32'(pc_misalign), 32'd1);
        npc_sel = 2'b00;
        step("seq_unaligned", 32'h0000_3006, 1'b0);

        fetch_hold = 1'b1; npc_sel = 2'b10; pc_id = 32'h0000_3020;
        step("hold_j3", 32'h0000_3006, 1'b0);
        chk("hold_pend_set3", 32'(pend_valid), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst_pc", pc, 32'h0000_3000);
        chk("async_rst_pend", 32'(pend_valid), 32'd0);
        chk("async_rst_if_jump", 32'(if_jump), 32'd0);
        #2;
        reset = 1'b0; fetch_hold = 1'b0; npc_sel = 2'b00;
        step("post_rst_seq", 32'h0000_3004, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
